pc_redirect_ctrl: RTL and testbench
===================================

PC_REDIRECT_CTRL -- requirements
Module: pc_redirect_ctrl

Interface
REQ-001 SHALL have parameter LU_STALL, default 1, meaning load-use bubble cycles, legal range 1..4.
REQ-002 SHALL have parameter CNT_W, default 16, meaning width of the statistics counters.
REQ-003 clk  input  1  clock; all state updates on posedge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 id_rs, id_rt  input  5 each  source register fields of the instruction in ID.
REQ-006 idex_memread, idex_rt  input  1, 5  load flag and destination register of the instruction in EX.
REQ-007 id_jump  input  1  the instruction in ID is a jump.
REQ-008 ex_branch, ex_zero  input  1 each  branch flag and ALU zero of the instruction in EX.
REQ-009 ex_branch_target  input  32  computed branch target in EX.
REQ-010 pcwrite, ifid_write  output  1 each  PC and IF/ID register update enables.
REQ-011 ifid_flush, idex_flush, exmem_flush  output  1 each  bubble-insert controls.
REQ-012 branch_ex_mem, zero_flag_ex_mem  output  1 each  registered EX/MEM branch flag and zero flag.
REQ-013 pc_branch_target_ex_mem  output  32  registered EX/MEM branch target.
REQ-014 pc_redirect  output  1  the PC loads pc_branch_target_ex_mem at the next edge.
REQ-015 stall_cnt, flush_cnt  output  CNT_W each  saturating event counters.

Function
REQ-016 pc_redirect SHALL equal branch_ex_mem AND zero_flag_ex_mem, combinationally.
REQ-017 The EX/MEM latch SHALL capture ex_branch, ex_zero and ex_branch_target on each posedge; branch_ex_mem SHALL capture 0 when pc_redirect is 1 in that cycle.
REQ-018 hazard SHALL equal idex_memread AND (idex_rt != 0) AND (idex_rt == id_rs OR idex_rt == id_rt).
REQ-019 The FSM SHALL have two states, RUN and STALL, plus a 2-bit bubble counter bcnt.
REQ-020 In RUN with pc_redirect = 1: ifid_flush = idex_flush = exmem_flush = 1, pcwrite = ifid_write = 1, and the next state SHALL be RUN.
REQ-021 In RUN with pc_redirect = 0 and hazard = 1: pcwrite = ifid_write = 0 and idex_flush = 1.
REQ-022 In the REQ-021 case the next state SHALL be RUN if LU_STALL = 1; otherwise the next state SHALL be STALL with bcnt = 1.
REQ-023 In STALL: pcwrite = ifid_write = 0 and idex_flush = 1; bcnt SHALL increment each cycle; the FSM SHALL return to RUN when bcnt == LU_STALL-1.
REQ-024 In STALL with pc_redirect = 1: REQ-020 outputs SHALL apply, the stall SHALL be aborted, and the next state SHALL be RUN with bcnt = 0.
REQ-025 Priority SHALL be: redirect, then load-use stall, then jump.
REQ-026 id_jump = 1 in RUN with no redirect and no hazard SHALL give ifid_flush = 1 with pcwrite = 1; id_jump SHALL be ignored while stalled.
REQ-027 With no event: pcwrite = ifid_write = 1 and all flush outputs = 0.
REQ-028 stall_cnt SHALL increment by 1 in every cycle pcwrite = 0 outside reset; flush_cnt SHALL increment on every pc_redirect cycle.
REQ-029 Both counters SHALL saturate at all-ones and never wrap.

Reset
REQ-030 While reset = 0: state RUN, bcnt = 0, EX/MEM latch = 0, counters = 0, pcwrite = ifid_write = 0, all flush outputs = 0.
REQ-031 Reset assertion mid-stall or mid-redirect SHALL take effect immediately, without waiting for clk.
REQ-032 The first posedge after reset release SHALL see pcwrite = 1.

Verification
REQ-033 Load-use, LU_STALL=1: idex_memread=1, idex_rt=5, id_rs=5 for one cycle -> pcwrite=0 and idex_flush=1 for exactly 1 cycle, stall_cnt=1.
REQ-034 Load-use, LU_STALL=3: same stimulus -> pcwrite=0 for 3 consecutive cycles, then 1; stall_cnt=3.
REQ-035 Taken branch: ex_branch=1, ex_zero=1, ex_branch_target=0x0000_0040 -> next cycle pc_redirect=1, pc_branch_target_ex_mem=0x40, all three flushes=1; following cycle branch_ex_mem=0; flush_cnt=1.
REQ-036 Redirect during stall: LU_STALL=3 hazard, then taken branch lands in the 2nd stall cycle -> pcwrite=1 with flushes in that cycle, state RUN next; hazard with idex_rt=0 -> no stall.
REQ-037 Jump and saturation: id_jump=1 alone -> ifid_flush=1, pcwrite=1; CNT_W=4 with 20 stall cycles -> stall_cnt=0xF.
REQ-038 Async reset: reset pulled low between clock edges during STALL -> all outputs and counters 0 immediately; after release, pcwrite=1.

Source files
------------

// File: rtl/pc_redirect_ctrl.sv
// Pipeline PC redirect and hazard controller: EX/MEM branch latch, load-use
// stall sequencing, jump/branch flush generation and saturating statistics.
module pc_redirect_ctrl #(
    parameter int unsigned LU_STALL = 1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             idex_memread,
    input  logic [4:0]       idex_rt,
    input  logic             id_jump,
    input  logic             ex_branch,
    input  logic             ex_zero,
    input  logic [31:0]      ex_branch_target,
    output logic             pcwrite,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             branch_ex_mem,
    output logic             zero_flag_ex_mem,
    output logic [31:0]      pc_branch_target_ex_mem,
    output logic             pc_redirect,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned BCNT_W    = 2;
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(LU_STALL - 1);

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    state_t            state, state_nx;
    logic [BCNT_W-1:0] bcnt, bcnt_nx;
    logic              hazard;

    assign pc_redirect = branch_ex_mem & zero_flag_ex_mem;

    assign hazard = idex_memread && (idex_rt != 5'd0) &&
                    ((idex_rt == id_rs) || (idex_rt == id_rt));

    // EX/MEM latch; a taken branch squashes the branch flag of its successor
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            branch_ex_mem           <= 1'b0;
            zero_flag_ex_mem        <= 1'b0;
            pc_branch_target_ex_mem <= 32'd0;
        end else begin
            branch_ex_mem           <= pc_redirect ? 1'b0 : ex_branch;
            zero_flag_ex_mem        <= ex_zero;
            pc_branch_target_ex_mem <= ex_branch_target;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
            bcnt  <= '0;
        end else begin
            state <= state_nx;
            bcnt  <= bcnt_nx;
        end
    end

    // Control outputs are gated by reset so they clear without a clock edge
    always_comb begin
        state_nx    = state;
        bcnt_nx     = bcnt;
        pcwrite     = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        if (!reset) begin
            pcwrite    = 1'b0;
            ifid_write = 1'b0;
            state_nx   = RUN;
            bcnt_nx    = '0;
        end else if (pc_redirect) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            state_nx    = RUN;
            bcnt_nx     = '0;
        end else begin
            case (state)
                RUN: begin
                    if (hazard) begin
                        pcwrite    = 1'b0;
                        ifid_write = 1'b0;
                        idex_flush = 1'b1;
                        if (LU_STALL > 1) begin
                            state_nx = STALL;
                            bcnt_nx  = BCNT_W'(1);
                        end
                    end else if (id_jump) begin
                        ifid_flush = 1'b1;
                    end
                end
                STALL: begin
                    pcwrite    = 1'b0;
                    ifid_write = 1'b0;
                    idex_flush = 1'b1;
                    if (bcnt == BCNT_LAST) begin
                        state_nx = RUN;
                        bcnt_nx  = '0;
                    end else begin
                        bcnt_nx = bcnt + BCNT_W'(1);
                    end
                end
                default: begin
                    state_nx = RUN;
                    bcnt_nx  = '0;
                end
            endcase
        end
    end

    // Saturating statistics counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!pcwrite && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (pc_redirect && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed bench for pc_redirect_ctrl: three instances (LU_STALL=1, LU_STALL=3,
// CNT_W=4) share one stimulus set; each task checks the instance it targets.
module tb_pc_redirect_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  id_rs, id_rt, idex_rt;
    logic        idex_memread, id_jump, ex_branch, ex_zero;
    logic [31:0] ex_branch_target;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    logic        a_pcw, a_ifw, a_iff, a_idf, a_exf, a_bem, a_zem, a_red;
    logic [31:0] a_tgt;
    logic [15:0] a_scnt, a_fcnt;
    logic        b_pcw, b_ifw, b_iff, b_idf, b_exf, b_bem, b_zem, b_red;
    logic [31:0] b_tgt;
    logic [15:0] b_scnt, b_fcnt;
    logic        c_pcw, c_ifw, c_iff, c_idf, c_exf, c_bem, c_zem, c_red;
    logic [31:0] c_tgt;
    logic [3:0]  c_scnt, c_fcnt;

    pc_redirect_ctrl #(.LU_STALL(1), .CNT_W(16)) u_lu1 (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
        .idex_memread(idex_memread), .idex_rt(idex_rt), .id_jump(id_jump),
        .ex_branch(ex_branch), .ex_zero(ex_zero), .ex_branch_target(ex_branch_target),
        .pcwrite(a_pcw), .ifid_write(a_ifw), .ifid_flush(a_iff), .idex_flush(a_idf),
        .exmem_flush(a_exf), .branch_ex_mem(a_bem), .zero_flag_ex_mem(a_zem),
        .pc_branch_target_ex_mem(a_tgt), .pc_redirect(a_red),
        .stall_cnt(a_scnt), .flush_cnt(a_fcnt));

    pc_redirect_ctrl #(.LU_STALL(3), .CNT_W(16)) u_lu3 (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
        .idex_memread(idex_memread), .idex_rt(idex_rt), .id_jump(id_jump),
        .ex_branch(ex_branch), .ex_zero(ex_zero), .ex_branch_target(ex_branch_target),
        .pcwrite(b_pcw), .ifid_write(b_ifw), .ifid_flush(b_iff), .idex_flush(b_idf),
        .exmem_flush(b_exf), .branch_ex_mem(b_bem), .zero_flag_ex_mem(b_zem),
        .pc_branch_target_ex_mem(b_tgt), .pc_redirect(b_red),
        .stall_cnt(b_scnt), .flush_cnt(b_fcnt));

    pc_redirect_ctrl #(.LU_STALL(1), .CNT_W(4)) u_cnt4 (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
        .idex_memread(idex_memread), .idex_rt(idex_rt), .id_jump(id_jump),
        .ex_branch(ex_branch), .ex_zero(ex_zero), .ex_branch_target(ex_branch_target),
        .pcwrite(c_pcw), .ifid_write(c_ifw), .ifid_flush(c_iff), .idex_flush(c_idf),
        .exmem_flush(c_exf), .branch_ex_mem(c_bem), .zero_flag_ex_mem(c_zem),
        .pc_branch_target_ex_mem(c_tgt), .pc_redirect(c_red),
        .stall_cnt(c_scnt), .flush_cnt(c_fcnt));

    task automatic idle_inputs();
        id_rs = 5'd0; id_rt = 5'd0; idex_rt = 5'd0; idex_memread = 1'b0;
        id_jump = 1'b0; ex_branch = 1'b0; ex_zero = 1'b0; ex_branch_target = 32'd0;
    endtask

    task automatic set_hazard();
        idex_memread = 1'b1; idex_rt = 5'd5; id_rs = 5'd5;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        #12;
        tests++;
        if ({a_pcw, a_ifw, a_iff, a_idf, a_exf, a_bem, a_zem, a_red} !== 8'h00) begin
            fails++; $display("FAIL reset_ctrl: got %b want 00000000",
                {a_pcw, a_ifw, a_iff, a_idf, a_exf, a_bem, a_zem, a_red});
        end
        tests++;
        if (a_scnt !== 16'd0 || a_fcnt !== 16'd0 || a_tgt !== 32'd0) begin
            fails++; $display("FAIL reset_state: scnt=%0d fcnt=%0d tgt=%h want 0", a_scnt, a_fcnt, a_tgt);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        tests++;
        if (a_pcw !== 1'b1 || a_ifw !== 1'b1 || b_pcw !== 1'b1) begin
            fails++; $display("FAIL reset_release: pcwrite=%b/%b ifid_write=%b want 1", a_pcw, b_pcw, a_ifw);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        @(negedge clk);
        set_hazard();
        #1;
        tests++;
        if (a_pcw !== 1'b0 || a_idf !== 1'b1 || a_ifw !== 1'b0 || b_pcw !== 1'b0) begin
            fails++; $display("FAIL lu_first: pcw=%b idf=%b ifw=%b b_pcw=%b want 0 1 0 0", a_pcw, a_idf, a_ifw, b_pcw);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        tests++;
        if (a_pcw !== 1'b1 || a_idf !== 1'b0 || b_pcw !== 1'b0 || b_idf !== 1'b1) begin
            fails++; $display("FAIL lu_second: a_pcw=%b a_idf=%b b_pcw=%b b_idf=%b want 1 0 0 1", a_pcw, a_idf, b_pcw, b_idf);
        end
        @(negedge clk);
        #1;
        tests++;
        if (b_pcw !== 1'b0) begin
            fails++; $display("FAIL lu3_third: pcwrite=%b want 0", b_pcw);
        end
        @(negedge clk);
        #1;
        tests++;
        if (b_pcw !== 1'b1 || b_idf !== 1'b0) begin
            fails++; $display("FAIL lu3_release: pcwrite=%b idf=%b want 1 0", b_pcw, b_idf);
        end
        tests++;
        if (a_scnt !== 16'd1 || b_scnt !== 16'd3) begin
            fails++; $display("FAIL lu_stall_cnt: lu1=%0d lu3=%0d want 1 3", a_scnt, b_scnt);
        end
    endtask

    task automatic test_branch();
        do_reset();
        @(negedge clk);
        ex_branch = 1'b1; ex_zero = 1'b0; ex_branch_target = 32'h0000_0100;
        @(negedge clk);
        #1;
        tests++;
        if (a_red !== 1'b0 || a_bem !== 1'b1 || a_iff !== 1'b0) begin
            fails++; $display("FAIL branch_not_taken: red=%b bem=%b iff=%b want 0 1 0", a_red, a_bem, a_iff);
        end
        ex_branch = 1'b1; ex_zero = 1'b1; ex_branch_target = 32'h0000_0040;
        @(negedge clk);
        ex_branch_target = 32'h0000_0080;
        #1;
        tests++;
        if (a_red !== 1'b1 || a_tgt !== 32'h40 ||
            {a_iff, a_idf, a_exf, a_pcw, a_ifw} !== 5'b11111) begin
            fails++; $display("FAIL branch_taken: red=%b tgt=%h flush/pcw=%b want 1 00000040 11111",
                a_red, a_tgt, {a_iff, a_idf, a_exf, a_pcw, a_ifw});
        end
        @(negedge clk);
        idle_inputs();
        #1;
        tests++;
        if (a_bem !== 1'b0 || a_red !== 1'b0 || a_zem !== 1'b1 || a_tgt !== 32'h80) begin
            fails++; $display("FAIL branch_squash: bem=%b red=%b zem=%b tgt=%h want 0 0 1 00000080",
                a_bem, a_red, a_zem, a_tgt);
        end
        tests++;
        if (a_fcnt !== 16'd1 || a_scnt !== 16'd0) begin
            fails++; $display("FAIL branch_cnt: flush_cnt=%0d stall_cnt=%0d want 1 0", a_fcnt, a_scnt);
        end
    endtask

    task automatic test_redirect_in_stall();
        do_reset();
        @(negedge clk);
        set_hazard();
        ex_branch = 1'b1; ex_zero = 1'b1; ex_branch_target = 32'h0000_0200;
        #1;
        tests++;
        if (b_pcw !== 1'b0 || b_red !== 1'b0) begin
            fails++; $display("FAIL rds_hazard: pcw=%b red=%b want 0 0", b_pcw, b_red);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        tests++;
        if (b_red !== 1'b1 || {b_pcw, b_ifw, b_iff, b_idf, b_exf} !== 5'b11111) begin
            fails++; $display("FAIL rds_abort: red=%b pcw/ifw/flush=%b want 1 11111",
                b_red, {b_pcw, b_ifw, b_iff, b_idf, b_exf});
        end
        @(negedge clk);
        #1;
        tests++;
        if (b_pcw !== 1'b1 || b_idf !== 1'b0 || b_iff !== 1'b0 || b_scnt !== 16'd1) begin
            fails++; $display("FAIL rds_run: pcw=%b idf=%b iff=%b scnt=%0d want 1 0 0 1", b_pcw, b_idf, b_iff, b_scnt);
        end
        idex_memread = 1'b1; idex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
        #1;
        tests++;
        if (b_pcw !== 1'b1 || b_idf !== 1'b0 || a_pcw !== 1'b1) begin
            fails++; $display("FAIL rt_zero: pcw=%b idf=%b a_pcw=%b want 1 0 1", b_pcw, b_idf, a_pcw);
        end
        idex_rt = 5'd7; id_rt = 5'd7;
        #1;
        tests++;
        if (a_pcw !== 1'b0 || a_idf !== 1'b1) begin
            fails++; $display("FAIL rt_match: pcw=%b idf=%b want 0 1", a_pcw, a_idf);
        end
        idle_inputs();
    endtask

    task automatic test_jump();
        do_reset();
        @(negedge clk);
        id_jump = 1'b1;
        #1;
        tests++;
        if (a_iff !== 1'b1 || a_pcw !== 1'b1 || a_idf !== 1'b0 || a_exf !== 1'b0) begin
            fails++; $display("FAIL jump_alone: iff=%b pcw=%b idf=%b exf=%b want 1 1 0 0", a_iff, a_pcw, a_idf, a_exf);
        end
        set_hazard();
        #1;
        tests++;
        if (a_iff !== 1'b0 || a_pcw !== 1'b0 || a_idf !== 1'b1) begin
            fails++; $display("FAIL jump_vs_hazard: iff=%b pcw=%b idf=%b want 0 0 1", a_iff, a_pcw, a_idf);
        end
        @(negedge clk);
        idle_inputs();
        id_jump = 1'b1;
        #1;
        tests++;
        if (b_iff !== 1'b0 || b_pcw !== 1'b0 || a_iff !== 1'b1) begin
            fails++; $display("FAIL jump_in_stall: b_iff=%b b_pcw=%b a_iff=%b want 0 0 1", b_iff, b_pcw, a_iff);
        end
        idle_inputs();
    endtask

    task automatic test_saturation();
        do_reset();
        @(negedge clk);
        set_hazard();
        repeat (20) @(negedge clk);
        idle_inputs();
        #1;
        tests++;
        if (c_scnt !== 4'hF || a_scnt !== 16'd20 || b_scnt !== 16'd20) begin
            fails++; $display("FAIL saturation: cnt4=%h lu1=%0d lu3=%0d want f 20 20", c_scnt, a_scnt, b_scnt);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        @(negedge clk);
        set_hazard();
        @(negedge clk);
        idle_inputs();
        #2;
        tests++;
        if (b_idf !== 1'b1 || b_scnt !== 16'd1) begin
            fails++; $display("FAIL async_pre: idf=%b scnt=%0d want 1 1", b_idf, b_scnt);
        end
        reset = 1'b0;
        #1;
        tests++;
        if ({b_pcw, b_ifw, b_iff, b_idf, b_exf, b_red} !== 6'b0 || b_scnt !== 16'd0 || b_fcnt !== 16'd0) begin
            fails++; $display("FAIL async_reset: ctrl=%b scnt=%0d fcnt=%0d want 000000 0 0",
                {b_pcw, b_ifw, b_iff, b_idf, b_exf, b_red}, b_scnt, b_fcnt);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        tests++;
        if (b_pcw !== 1'b1 || b_idf !== 1'b0) begin
            fails++; $display("FAIL async_release: pcw=%b idf=%b want 1 0", b_pcw, b_idf);
        end
        @(negedge clk);
        #1;
        tests++;
        if (b_pcw !== 1'b1 || b_scnt !== 16'd0) begin
            fails++; $display("FAIL async_run: pcw=%b scnt=%0d want 1 0", b_pcw, b_scnt);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_redirect_in_stall();
        test_jump();
        test_saturation();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
